// File: rtl/dec_comparator_pipe.sv
// Two-stage pipelined codeword comparator: masked XOR in S1, equality/popcount/lowest-index in S2,
// plus a saturating count of mismatching results delivered downstream.
module dec_comparator_pipe #(
   parameter int unsigned  DATA_WIDTH = 32,
   parameter int unsigned  MODE_W     = 2,
   parameter int unsigned  CNT_WIDTH  = 16,
   localparam int unsigned IDX_W      = $clog2(DATA_WIDTH),
   localparam int unsigned CW         = IDX_W + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic [MODE_W-1:0]     codeword_width,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  isEqual,
   output logic [CW-1:0]         mismatch_cnt,
   output logic [IDX_W-1:0]      first_idx,
   input  logic                  clr_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt
);

   logic                  s1_valid_q, s1_valid_d;
   logic [DATA_WIDTH-1:0] s1_x_q, s1_x_d;
   logic                  s2_valid_q, s2_valid_d;
   logic                  s2_eq_q, s2_eq_d;
   logic [CW-1:0]         s2_cnt_q, s2_cnt_d;
   logic [IDX_W-1:0]      s2_idx_q, s2_idx_d;
   logic [CNT_WIDTH-1:0]  err_q, err_d;

   logic                  advance_c;
   logic                  accept_c;
   logic [DATA_WIDTH-1:0] mask_c;
   int unsigned           eff_w_c;
   logic [CW-1:0]         pop_c;
   logic [IDX_W-1:0]      idx_c;
   logic                  found_c;

   // Effective width is 8 << mode, clamped to DATA_WIDTH before the shift can overflow.
   always_comb begin
      eff_w_c = DATA_WIDTH;
      if (32'(codeword_width) + 32'd3 < IDX_W) begin
         eff_w_c = 32'd8 << codeword_width;
      end
      mask_c = '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         mask_c[i] = (i < eff_w_c);
      end
   end

   // Popcount and lowest set bit of the S1 difference vector.
   always_comb begin
      pop_c   = '0;
      idx_c   = '0;
      found_c = 1'b0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         if (s1_x_q[i]) begin
            pop_c = pop_c + CW'(1);
            if (!found_c) begin
               idx_c   = IDX_W'(i);
               found_c = 1'b1;
            end
         end
      end
   end

   // Global-stall pipeline control and error counter next state.
   always_comb begin
      advance_c  = !s2_valid_q || out_ready;
      in_ready   = advance_c;
      accept_c   = in_valid && advance_c;
      s1_valid_d = s1_valid_q;
      s1_x_d     = s1_x_q;
      s2_valid_d = s2_valid_q;
      s2_eq_d    = s2_eq_q;
      s2_cnt_d   = s2_cnt_q;
      s2_idx_d   = s2_idx_q;
      err_d      = err_q;

      if (advance_c) begin
         s1_valid_d = accept_c;
         if (accept_c) begin
            s1_x_d = (A ^ B) & mask_c;
         end
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_eq_d  = (s1_x_q == '0);
            s2_cnt_d = pop_c;
            s2_idx_d = idx_c;
         end
      end

      // Clear takes priority over a same-cycle increment.
      if (clr_cnt) begin
         err_d = '0;
      end else if (s2_valid_q && out_ready && !s2_eq_q && (err_q != '1)) begin
         err_d = err_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s1_x_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_eq_q    <= 1'b0;
         s2_cnt_q   <= '0;
         s2_idx_q   <= '0;
         err_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_x_q     <= s1_x_d;
         s2_valid_q <= s2_valid_d;
         s2_eq_q    <= s2_eq_d;
         s2_cnt_q   <= s2_cnt_d;
         s2_idx_q   <= s2_idx_d;
         err_q      <= err_d;
      end
   end

   assign out_valid    = s2_valid_q;
   assign isEqual      = s2_eq_q;
   assign mismatch_cnt = s2_cnt_q;
   assign first_idx    = s2_idx_q;
   assign err_cnt      = err_q;

endmodule
